// File: rtl/poc_alu.sv
// 18-bit registered ALU for the execute stage: result c = f(alu_sel, a, b), flags lsb = c[0], neg = c[17].
// Latency: one cycle. Inputs are sampled at a rising edge and the outputs hold until the next update.
// No handshake or backpressure. NOP (opcode 0) holds c and both flags.
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst_n    in   1   synchronous active-low reset; clears c, lsb and neg
//   alu_sel  in   4   opcode
//   a        in   18  operand A
//   b        in   18  operand B
//   c        out  18  registered result
//   lsb      out  1   registered copy of result bit 0
//   neg      out  1   registered copy of result bit 17
module poc_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  alu_sel,
  input  logic [17:0] a,
  input  logic [17:0] b,
  output logic [17:0] c,
  output logic        lsb,
  output logic        neg
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_INC   = 4'd8,
    OP_DEC   = 4'd9,
    OP_SHR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_PASSA = 4'd12,
    OP_PASSB = 4'd13,
    OP_NEG   = 4'd14,
    OP_CLR   = 4'd15
  } op_t;

  op_t         op;
  logic [17:0] r;
  logic        upd;

  assign op = op_t'(alu_sel);

  // All operations are evaluated in 18 bits, so the arithmetic wraps
  // modulo 2^18 and the multiply keeps only the low half of the product.
  always_comb begin
    r   = c;
    upd = 1'b1;
    unique case (op)
      OP_NOP:   begin r = c; upd = 1'b0; end
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_MUL:   r = a * b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_INC:   r = a + 18'd1;
      OP_DEC:   r = a - 18'd1;
      OP_SHR:   r = {1'b0, a[17:1]};
      OP_SHL:   r = {a[16:0], 1'b0};
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_NEG:   r = 18'd0 - a;
      OP_CLR:   r = 18'd0;
      default:  begin r = c; upd = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c   <= 18'd0;
      lsb <= 1'b0;
      neg <= 1'b0;
    end else if (upd) begin
      c   <= r;
      lsb <= r[0];
      neg <= r[17];
    end
  end

endmodule

// File: tb/tb_poc_alu.sv
// Bench for poc_alu: directed opcode cases plus random operations compared with an arithmetic model.
// Latency: one result per clock. Outputs are checked 1 ns after each rising edge.
// No backpressure. Inputs are also checked to have no effect on c before the edge.
module tb_poc_alu;

  localparam int unsigned M = 262144; // 2^18

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_sel;
  logic [17:0] a;
  logic [17:0] b;
  logic [17:0] c;
  logic        lsb;
  logic        neg;

  int errors = 0;
  int checks = 0;
  int unsigned exp_c = 0;
  bit have_ref = 0;

  poc_alu dut (
    .clk(clk), .rst_n(rst_n), .alu_sel(alu_sel),
    .a(a), .b(b), .c(c), .lsb(lsb), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the opcode rules written as modulo-2^18 integer arithmetic.
  function automatic int unsigned ref_op(int unsigned sel, int unsigned x,
                                         int unsigned y, int unsigned cur);
    longint unsigned p;
    case (sel)
      0:  return cur;
      1:  return (x + y) % M;
      2:  return (x + M - y) % M;
      3:  begin p = longint'(x) * longint'(y); return int'(p % M); end
      4:  return x & y;
      5:  return x | y;
      6:  return x ^ y;
      7:  return M - 1 - x;
      8:  return (x + 1) % M;
      9:  return (x + M - 1) % M;
      10: return x / 2;
      11: return (x * 2) % M;
      12: return x;
      13: return y;
      14: return (M - x) % M;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%05h expected=0x%05h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_c"}, c, 18'(exp_c));
    chk({tag, "_lsb"}, {17'd0, lsb}, 18'(exp_c % 2));
    chk({tag, "_neg"}, {17'd0, neg}, (exp_c >= M / 2) ? 18'd1 : 18'd0);
  endtask

  // Drive one set of inputs away from the edge, confirm the outputs have not
  // moved yet, then clock it in and compare with the model.
  task automatic step(input logic r, input logic [3:0] sel,
                      input logic [17:0] av, input logic [17:0] bv, input string tag);
    @(negedge clk);
    rst_n   = r;
    alu_sel = sel;
    a       = av;
    b       = bv;
    #1;
    if (have_ref) chk({tag, "_pre"}, c, 18'(exp_c));
    @(posedge clk);
    #1;
    if (!r) begin
      exp_c    = 0;
      have_ref = 1;
    end else if (have_ref) begin
      exp_c = ref_op(sel, av, bv, exp_c);
    end
    if (have_ref) chk_out(tag);
  endtask

  initial begin
    rst_n = 1'b1; alu_sel = 4'd0; a = 18'd0; b = 18'd0;

    // Reset has priority over ADD; releasing it lets the ADD through.
    step(1'b0, 4'd1, 18'd6, 18'd4, "t1_rst");
    chk("t1_rst_lit", c, 18'd0);
    step(1'b1, 4'd1, 18'd6, 18'd4, "t1_add");
    chk("t1_add_lit", c, 18'd10);

    // ADD followed by NOP holding the result while operands change.
    step(1'b1, 4'd1, 18'd6, 18'd4, "t2_add");
    step(1'b1, 4'd0, 18'd77, 18'd99, "t2_nop");
    chk("t2_nop_lit", c, 18'd10);

    // SHR ignores b.
    step(1'b1, 4'd10, 18'd66822, 18'd0, "t3_shr1");
    chk("t3_shr1_lit", c, 18'd33411);
    step(1'b1, 4'd10, 18'd0, 18'd66822, "t3_shr2");
    chk("t3_shr2_lit", c, 18'd0);

    // Wrap-around in both directions.
    step(1'b1, 4'd2, 18'd4, 18'd6, "t4_sub");
    chk("t4_sub_lit", c, 18'h3FFFE);
    step(1'b1, 4'd1, 18'h3FFFF, 18'd1, "t4_addwrap");
    chk("t4_addwrap_lit", c, 18'd0);
    step(1'b1, 4'd2, 18'd0, 18'd1, "t4_subwrap");
    chk("t4_subwrap_lit", c, 18'h3FFFF);
    step(1'b1, 4'd9, 18'd0, 18'd0, "t4_dec0");
    chk("t4_dec0_lit", c, 18'h3FFFF);
    step(1'b1, 4'd14, 18'd0, 18'd5, "t4_neg0");
    chk("t4_neg0_lit", c, 18'd0);

    // Truncated multiply.
    step(1'b1, 4'd3, 18'd1000, 18'd300, "t5_mul");
    chk("t5_mul_lit", c, 18'd37856);

    // Logic and shift sweep with fixed operands.
    step(1'b1, 4'd4,  18'h2AAAA, 18'h0FFFF, "t6_and"); chk("t6_and_lit", c, 18'h0AAAA);
    step(1'b1, 4'd5,  18'h2AAAA, 18'h0FFFF, "t6_or");  chk("t6_or_lit",  c, 18'h2FFFF);
    step(1'b1, 4'd6,  18'h2AAAA, 18'h0FFFF, "t6_xor"); chk("t6_xor_lit", c, 18'h25555);
    step(1'b1, 4'd7,  18'h2AAAA, 18'h0FFFF, "t6_not"); chk("t6_not_lit", c, 18'h15555);
    step(1'b1, 4'd11, 18'h2AAAA, 18'h0FFFF, "t6_shl"); chk("t6_shl_lit", c, 18'h15554);
    step(1'b1, 4'd14, 18'h2AAAA, 18'h0FFFF, "t6_neg"); chk("t6_neg_lit", c, 18'h15556);
    step(1'b1, 4'd12, 18'h2AAAA, 18'h0FFFF, "t6_pa");  chk("t6_pa_lit",  c, 18'h2AAAA);
    step(1'b1, 4'd13, 18'h2AAAA, 18'h0FFFF, "t6_pb");  chk("t6_pb_lit",  c, 18'h0FFFF);
    step(1'b1, 4'd8,  18'h3FFFF, 18'h0,     "t6_inc"); chk("t6_inc_lit", c, 18'h0);
    step(1'b1, 4'd15, 18'h2AAAA, 18'h0FFFF, "t6_clr"); chk("t6_clr_lit", c, 18'h0);

    // Random opcodes and operands, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [3:0]  s;
      logic [17:0] av;
      logic [17:0] bv;
      r  = ($urandom_range(0, 31) != 0);
      s  = 4'($urandom_range(0, 15));
      av = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom);
      bv = ($urandom_range(0, 7) == 0) ? 18'h00000 : 18'($urandom);
      step(r, s, av, bv, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
